spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 201 ++++++++++++++++++++
 tb/tb_spi_slave.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0) byte-wide slave, MSB first.
// sclk, mosi and cs_n are asynchronous to raw_clk. Each passes through
// SYNC_STAGES flops, and edges are detected against a delay flop.
//
// Ports
//   raw_clk      system clock; all logic runs on its rising edge
//   reset_n      asynchronous active-low reset
//   sclk/mosi    SPI clock and data from the master
//   cs_n         active-low chip select
//   miso/miso_oe slave data out (MSB first) and its enable (high while selected)
//   tx_data      byte to transmit; written by the tx_write strobe
//   tx_empty     TX holding register is empty
//   rx_data      last complete received byte
//   rx_valid     one-cycle pulse when rx_data updates
//   rx_full      set with rx_valid, cleared by rx_ack
//   rx_ack       host acknowledge strobe
//   overrun      sticky; set when a byte lands while rx_full is still set
//   busy         selected with a nonzero bit count
//
// Build option: define SPI_SLAVE_OVERRUN_EN to enable the overrun flag.
// Without it, overrun is tied to 0.
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2  // minimum 2
) (
  input  logic       raw_clk,
  input  logic       reset_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_write,
  output logic       tx_empty,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_full,
  input  logic       rx_ack,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;
  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sclk_dly_q, cs_dly_q;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] fall_cnt_q, fall_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       tx_empty_q, tx_empty_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_full_q, rx_full_d;
  logic       byte_done, hold_load;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s &  sclk_dly_q;
  assign cs_fall   = ~cs_s   &  cs_dly_q;
  assign cs_rise   =  cs_s   & ~cs_dly_q;

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
    end
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      fall_cnt_q <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      tx_empty_q <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_full_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      fall_cnt_q <= fall_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      tx_empty_q <= tx_empty_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_full_q  <= rx_full_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    fall_cnt_d = fall_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_empty_d = tx_empty_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    byte_done  = 1'b0;
    hold_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d    = ST_ACTIVE;
          bit_cnt_d  = '0;
          fall_cnt_d = '0;
          rx_shift_d = '0;
          hold_load  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          // Deselect drops the partial frame; the holding register is kept.
          state_d    = ST_IDLE;
          bit_cnt_d  = '0;
          fall_cnt_d = '0;
          rx_shift_d = '0;
          tx_shift_d = '0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            byte_done  = (bit_cnt_q == 3'd7);
          end
          if (sclk_fall) begin
            // Falls are counted separately so that the 8th fall reloads the
            // shifter instead of shifting it.
            fall_cnt_d = fall_cnt_q + 3'd1;
            if (fall_cnt_q == 3'd7) hold_load = 1'b1;
            else                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (hold_load) begin
      tx_shift_d = tx_empty_q ? 8'h00 : tx_hold_q;
      tx_empty_d = 1'b1;
    end
    // A load in the same cycle frees the holding register, so the write lands.
    if (tx_write && (tx_empty_q || hold_load)) begin
      tx_hold_d  = tx_data;
      tx_empty_d = 1'b0;
    end

    if (byte_done) begin
      rx_data_d  = rx_shift_d;
      rx_valid_d = 1'b1;
    end
    // A completing byte wins over a simultaneous acknowledge.
    if (byte_done)   rx_full_d = 1'b1;
    else if (rx_ack) rx_full_d = 1'b0;
    else             rx_full_d = rx_full_q;
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun_q;
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n)                    overrun_q <= 1'b0;
    else if (rx_ack)                 overrun_q <= 1'b0;
    else if (byte_done && rx_full_q) overrun_q <= 1'b1;
  end
  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign miso     = (state_q == ST_ACTIVE) & tx_shift_q[7];
  assign miso_oe  = (state_q == ST_ACTIVE);
  assign busy     = (state_q == ST_ACTIVE) && (bit_cnt_q != 3'd0);
  assign tx_empty = tx_empty_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_full  = rx_full_q;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;
  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = 8;  // raw_clk cycles per sclk half period
`ifdef SPI_SLAVE_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic       raw_clk, reset_n, sclk, mosi, cs_n;
  logic       miso, miso_oe, tx_write, tx_empty, rx_valid, rx_full, rx_ack, overrun, busy;
  logic [7:0] tx_data, rx_data;

  int unsigned vec_cnt  = 0;
  int unsigned miss_cnt = 0;
  int unsigned valid_cycles = 0;

  spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .raw_clk (raw_clk),
    .reset_n (reset_n),
    .sclk    (sclk),
    .mosi    (mosi),
    .cs_n    (cs_n),
    .miso    (miso),
    .miso_oe (miso_oe),
    .tx_data (tx_data),
    .tx_write(tx_write),
    .tx_empty(tx_empty),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_full (rx_full),
    .rx_ack  (rx_ack),
    .overrun (overrun),
    .busy    (busy)
  );

  initial raw_clk = 1'b0;
  always #5 raw_clk = ~raw_clk;

  always @(negedge raw_clk) if (rx_valid === 1'b1) valid_cycles++;

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(negedge raw_clk);
  endtask

  task automatic host_write(input logic [7:0] d);
    tx_data  = d;
    tx_write = 1'b1;
    wait_clks(1);
    tx_write = 1'b0;
  endtask

  task automatic host_ack();
    rx_ack = 1'b1;
    wait_clks(1);
    rx_ack = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] b, input int unsigned nbits, output logic [7:0] got);
    logic [7:0] sh;
    sh  = b;
    got = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      mosi = sh[7];
      sh   = {sh[6:0], 1'b0};
      wait_clks(HALF);
      got  = {got[6:0], miso};
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
    end
    wait_clks(HALF);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
    tx_data = '0; tx_write = 1'b0; rx_ack = 1'b0;
    wait_clks(2);
    vec_cnt++;
    if ({miso, miso_oe, rx_valid, rx_full, overrun, tx_empty, busy} !== 7'b0000010) begin
      miss_cnt++;
      $display("FAIL reset_flags: got %b expected %b",
               {miso, miso_oe, rx_valid, rx_full, overrun, tx_empty, busy}, 7'b0000010);
    end
    vec_cnt++;
    if (rx_data !== 8'h00) begin
      miss_cnt++; $display("FAIL reset_rx_data: got %h expected 00", rx_data);
    end
    reset_n = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_basic();
    logic [7:0] g;
    int unsigned v0;
    host_write(8'hA5);
    vec_cnt++;
    if (tx_empty !== 1'b0) begin miss_cnt++; $display("FAIL basic_hold_full: got %b expected 0", tx_empty); end
    cs_n = 1'b0; wait_clks(HALF);
    vec_cnt++;
    if (miso_oe !== 1'b1) begin miss_cnt++; $display("FAIL basic_oe: got %b expected 1", miso_oe); end
    v0 = valid_cycles;
    spi_xfer(8'h3C, 8, g);
    vec_cnt++;
    if (g !== 8'hA5) begin miss_cnt++; $display("FAIL basic_miso: got %h expected a5", g); end
    vec_cnt++;
    if (rx_data !== 8'h3C) begin miss_cnt++; $display("FAIL basic_rx_data: got %h expected 3c", rx_data); end
    vec_cnt++;
    if (valid_cycles - v0 !== 1) begin miss_cnt++; $display("FAIL basic_rx_valid: got %0d pulses expected 1", valid_cycles - v0); end
    vec_cnt++;
    if ({tx_empty, rx_full} !== 2'b11) begin miss_cnt++; $display("FAIL basic_flags: got %b expected 11", {tx_empty, rx_full}); end
    cs_n = 1'b1; wait_clks(HALF);
    host_ack();
    vec_cnt++;
    if ({rx_full, miso_oe} !== 2'b00) begin miss_cnt++; $display("FAIL basic_ack: got %b expected 00", {rx_full, miso_oe}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g;
    int unsigned v0;
    cs_n = 1'b0; wait_clks(HALF);
    v0 = valid_cycles;
    spi_xfer(8'h01, 8, g);
    vec_cnt++;
    if ({rx_data, overrun} !== {8'h01, 1'b0}) begin miss_cnt++; $display("FAIL b2b_first: got %h/%b expected 01/0", rx_data, overrun); end
    spi_xfer(8'h80, 8, g);
    vec_cnt++;
    if (rx_data !== 8'h80) begin miss_cnt++; $display("FAIL b2b_rx_data: got %h expected 80", rx_data); end
    vec_cnt++;
    if (overrun !== OVR_EXP) begin miss_cnt++; $display("FAIL b2b_overrun: got %b expected %b", overrun, OVR_EXP); end
    vec_cnt++;
    if (valid_cycles - v0 !== 2) begin miss_cnt++; $display("FAIL b2b_rx_valid: got %0d pulses expected 2", valid_cycles - v0); end
    cs_n = 1'b1; wait_clks(HALF);
    host_ack();
    vec_cnt++;
    if ({rx_full, overrun} !== 2'b00) begin miss_cnt++; $display("FAIL b2b_ack_clear: got %b expected 00", {rx_full, overrun}); end
  endtask

  task automatic test_partial();
    logic [7:0] g;
    int unsigned v0;
    cs_n = 1'b0; wait_clks(HALF);
    v0 = valid_cycles;
    spi_xfer(8'hFF, 5, g);
    vec_cnt++;
    if (busy !== 1'b1) begin miss_cnt++; $display("FAIL partial_busy_mid: got %b expected 1", busy); end
    cs_n = 1'b1; wait_clks(HALF);
    vec_cnt++;
    if ({busy, miso_oe, miso} !== 3'b000) begin miss_cnt++; $display("FAIL partial_abort: got %b expected 000", {busy, miso_oe, miso}); end
    vec_cnt++;
    if (valid_cycles - v0 !== 0 || rx_full !== 1'b0) begin
      miss_cnt++; $display("FAIL partial_no_valid: got %0d pulses full=%b expected 0/0", valid_cycles - v0, rx_full);
    end
    cs_n = 1'b0; wait_clks(HALF);
    v0 = valid_cycles;
    spi_xfer(8'h96, 8, g);
    vec_cnt++;
    if (rx_data !== 8'h96 || valid_cycles - v0 !== 1) begin
      miss_cnt++; $display("FAIL partial_next: got %h/%0d expected 96/1", rx_data, valid_cycles - v0);
    end
    cs_n = 1'b1; wait_clks(HALF);
    host_ack();
  endtask

  task automatic test_empty_holding();
    logic [7:0] g;
    vec_cnt++;
    if (tx_empty !== 1'b1) begin miss_cnt++; $display("FAIL empty_pre: got %b expected 1", tx_empty); end
    cs_n = 1'b0; wait_clks(HALF);
    spi_xfer(8'hFF, 8, g);
    vec_cnt++;
    if (g !== 8'h00) begin miss_cnt++; $display("FAIL empty_miso: got %h expected 00", g); end
    vec_cnt++;
    if (rx_data !== 8'hFF) begin miss_cnt++; $display("FAIL empty_rx_data: got %h expected ff", rx_data); end
    cs_n = 1'b1; wait_clks(HALF);
    host_ack();
  endtask

  task automatic test_tx_collision();
    logic [7:0] g;
    host_write(8'hC3);
    host_write(8'h11);  // must be ignored: holding still full
    cs_n = 1'b0;
    wait_clks(SYNC);    // now in the cycle where the cs_n fall is detected
    tx_data = 8'h5A; tx_write = 1'b1;
    wait_clks(1);
    tx_write = 1'b0;
    vec_cnt++;
    if (tx_empty !== 1'b0) begin miss_cnt++; $display("FAIL coll_hold_full: got %b expected 0", tx_empty); end
    wait_clks(HALF);
    spi_xfer(8'h00, 8, g);
    vec_cnt++;
    if (g !== 8'hC3) begin miss_cnt++; $display("FAIL coll_shifter: got %h expected c3", g); end
    vec_cnt++;
    if (tx_empty !== 1'b1) begin miss_cnt++; $display("FAIL coll_reload: got %b expected 1", tx_empty); end
    spi_xfer(8'h00, 8, g);
    vec_cnt++;
    if (g !== 8'h5A) begin miss_cnt++; $display("FAIL coll_holding: got %h expected 5a", g); end
    cs_n = 1'b1; wait_clks(HALF);
    host_ack();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] g;
    int unsigned v0;
    host_write(8'h77);
    cs_n = 1'b0; wait_clks(HALF);
    spi_xfer(8'hF0, 4, g);
    host_write(8'h33);
    vec_cnt++;
    if ({busy, tx_empty} !== 2'b10) begin miss_cnt++; $display("FAIL midrst_pre: got %b expected 10", {busy, tx_empty}); end
    #2 reset_n = 1'b0;
    #1;
    vec_cnt++;
    if ({miso, miso_oe, rx_valid, rx_full, overrun, tx_empty, busy} !== 7'b0000010) begin
      miss_cnt++;
      $display("FAIL midrst_flags: got %b expected %b",
               {miso, miso_oe, rx_valid, rx_full, overrun, tx_empty, busy}, 7'b0000010);
    end
    vec_cnt++;
    if (rx_data !== 8'h00) begin miss_cnt++; $display("FAIL midrst_rx_data: got %h expected 00", rx_data); end
    cs_n = 1'b1; sclk = 1'b0;
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(4);
    host_write(8'hE1);
    cs_n = 1'b0; wait_clks(HALF);
    v0 = valid_cycles;
    spi_xfer(8'h42, 8, g);
    vec_cnt++;
    if (g !== 8'hE1) begin miss_cnt++; $display("FAIL midrst_next_miso: got %h expected e1", g); end
    vec_cnt++;
    if (rx_data !== 8'h42 || valid_cycles - v0 !== 1) begin
      miss_cnt++; $display("FAIL midrst_next_rx: got %h/%0d expected 42/1", rx_data, valid_cycles - v0);
    end
    cs_n = 1'b1; wait_clks(HALF);
    host_ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_partial();
    test_empty_holding();
    test_tx_collision();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
